// File: rtl/subvq_shortlist_frame_sched.sv
// ---------------------------------------------------------------------------
// subvq_shortlist_frame_sched
//
// Per-frame scheduler for the subvq mgau shortlist engine. A frame request
// runs the engine once for each codebook m = 0..n_eff-1. For each run the
// scheduler holds m and beam stable, waits for the engine score, acknowledges
// it, and writes the shortlist count into a per-mgau result RAM. It also
// accumulates the frame total.
//
// Optional feature: define SCHED_WATCHDOG_EN to enable the RUN watchdog.
// With the watchdog, a run that produces no score within TIMEOUT cycles
// stores all-ones, sets the sticky err flag, and resets the engine. Without
// the macro, RUN waits indefinitely and err is tied to 0.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   frame_start         one-cycle frame request (accepted only when idle)
//   n_mgau, beam        frame parameters, sampled on an accepted frame_start
//   eng_rst             engine init hold (1 = engine held in init)
//   eng_m, eng_beam     codebook index and latched beam driven to the engine
//   eng_score           engine shortlist count
//   eng_score_ready     engine score valid
//   eng_score_received  one-cycle acknowledge back to the engine
//   res_addr/data/we    result RAM write port
//   total_count         sum of the counts of the current frame
//   busy, frame_done    frame in progress / one-cycle completion pulse
//   err                 sticky watchdog error
//
// Timing: all outputs are registered. The per-state strobes (eng_rst,
// eng_score_received, res_we, frame_done) are decoded from the current state
// and appear one cycle after that state is entered.
// ---------------------------------------------------------------------------
module subvq_shortlist_frame_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int MGAU_W     = 8,
   parameter int N_MGAU_MAX = 3,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic [MGAU_W-1:0]     n_mgau,
   input  logic [DATA_WIDTH-1:0] beam,
   output logic                  eng_rst,
   output logic [DATA_WIDTH-1:0] eng_m,
   output logic [DATA_WIDTH-1:0] eng_beam,
   input  logic [DATA_WIDTH-1:0] eng_score,
   input  logic                  eng_score_ready,
   output logic                  eng_score_received,
   output logic [MGAU_W-1:0]     res_addr,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_we,
   output logic [DATA_WIDTH-1:0] total_count,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      RUN   = 3'd2,
      ACK   = 3'd3,
      STORE = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [MGAU_W-1:0] N_MAX = MGAU_W'(N_MGAU_MAX);

   state_t                  state, state_nx;
   logic [MGAU_W-1:0]       n_eff;
   logic [MGAU_W-1:0]       m;
   logic [DATA_WIDTH-1:0]   score_q;
   logic [MGAU_W-1:0]       n_eff_in;
   logic [MGAU_W:0]         m_inc;
   logic                    more;
   logic                    accept;
   logic                    timeout;

   // Decoded strobe values. They are registered below so every output is a flop.
   logic eng_rst_d, received_d, res_we_d, frame_done_d;

   // busy stays high through the frame_done cycle. This blocks a frame_start
   // that arrives in that cycle even though the FSM is already back in IDLE.
   assign accept   = (state == IDLE) && frame_start && !busy;
   assign n_eff_in = (n_mgau > N_MAX) ? N_MAX : n_mgau;
   assign m_inc    = {1'b0, m} + {{MGAU_W{1'b0}}, 1'b1};
   assign more     = m_inc < {1'b0, n_eff};

`ifdef SCHED_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             timed_out;

   // The counter is zero outside RUN, so it starts from zero each time RUN is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                wd_cnt <= '0;
      else if (state != RUN)  wd_cnt <= '0;
      else                    wd_cnt <= wd_cnt + 1'b1;
   end

   assign timeout = (state == RUN) && !eng_score_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------- next-state logic ----------------
   // NOTE: state_nx gets a default first, so no path through the block infers a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = (n_eff_in == '0) ? DONE : SETUP;
         SETUP:   state_nx = RUN;
         RUN: begin
            if (eng_score_ready) state_nx = ACK;
            else if (timeout)    state_nx = STORE;
         end
         ACK:     state_nx = STORE;
         STORE:   state_nx = more ? SETUP : DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      eng_rst_d    = 1'b1;
      received_d   = 1'b0;
      res_we_d     = 1'b0;
      frame_done_d = 1'b0;
      unique case (state)
         RUN:     eng_rst_d = 1'b0;
         ACK: begin
            eng_rst_d  = 1'b0;
            received_d = 1'b1;
         end
         STORE:   res_we_d = 1'b1;
         DONE:    frame_done_d = 1'b1;
         default: ;
      endcase
   end

   // ---------------- registered outputs and datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_rst            <= 1'b1;
         eng_score_received <= 1'b0;
         res_we             <= 1'b0;
         frame_done         <= 1'b0;
         eng_m              <= '0;
         eng_beam           <= '0;
         res_addr           <= '0;
         res_data           <= '0;
         total_count        <= '0;
         busy               <= 1'b0;
         n_eff              <= '0;
         m                  <= '0;
         score_q            <= '0;
`ifdef SCHED_WATCHDOG_EN
         err                <= 1'b0;
         timed_out          <= 1'b0;
`endif
      end else begin
         eng_rst            <= eng_rst_d;
         eng_score_received <= received_d;
         res_we             <= res_we_d;
         frame_done         <= frame_done_d;

         if (accept) begin
            n_eff       <= n_eff_in;
            eng_beam    <= beam;
            m           <= '0;
            total_count <= '0;
            busy        <= 1'b1;
`ifdef SCHED_WATCHDOG_EN
            err         <= 1'b0;
`endif
         end else if (frame_done) begin
            busy <= 1'b0;
         end

         // eng_m is loaded in SETUP, which is at least one edge before eng_rst drops.
         if (state == SETUP)
            eng_m <= {{(DATA_WIDTH-MGAU_W){1'b0}}, m};

         if (state == RUN) begin
            if (eng_score_ready) begin
               score_q <= eng_score;
`ifdef SCHED_WATCHDOG_EN
               timed_out <= 1'b0;
`endif
            end
`ifdef SCHED_WATCHDOG_EN
            else if (timeout) begin
               score_q   <= '1;
               timed_out <= 1'b1;
               err       <= 1'b1;
            end
`endif
         end

         if (state == STORE) begin
            res_addr <= m;
            res_data <= score_q;
`ifdef SCHED_WATCHDOG_EN
            // The all-ones timeout marker is recorded in the RAM but not counted.
            if (!timed_out) total_count <= total_count + score_q;
`else
            total_count <= total_count + score_q;
`endif
            if (more) m <= m_inc[MGAU_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_subvq_shortlist_frame_sched.sv
// ---------------------------------------------------------------------------
// Directed bench for subvq_shortlist_frame_sched. A behavioural engine model
// returns score_tab[m] after ENG_LAT cycles out of init. Monitors record the
// result writes, the codebook index at each run start, and the frame_done
// pulses.
// ---------------------------------------------------------------------------
module tb_subvq_shortlist_frame_sched;

   localparam int          DW      = 32;
   localparam int          MW      = 8;
   localparam int          ENG_LAT = 20;
   localparam logic [31:0] BEAM_A  = 32'hFFFF_3CB0;   // -50000
   localparam logic [31:0] BEAM_B  = 32'h0000_1234;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic [MW-1:0] n_mgau = '0;
   logic [DW-1:0] beam = '0;
   logic          eng_rst;
   logic [DW-1:0] eng_m, eng_beam;
   logic [DW-1:0] eng_score = '0;
   logic          eng_score_ready = 1'b0;
   logic          eng_score_received;
   logic [MW-1:0] res_addr;
   logic [DW-1:0] res_data;
   logic          res_we;
   logic [DW-1:0] total_count;
   logic          busy, frame_done, err;

   int n_assert = 0;
   int n_fail   = 0;

   subvq_shortlist_frame_sched #(
      .DATA_WIDTH(DW), .MGAU_W(MW), .N_MGAU_MAX(3), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .n_mgau(n_mgau), .beam(beam),
      .eng_rst(eng_rst), .eng_m(eng_m), .eng_beam(eng_beam), .eng_score(eng_score),
      .eng_score_ready(eng_score_ready), .eng_score_received(eng_score_received),
      .res_addr(res_addr), .res_data(res_data), .res_we(res_we),
      .total_count(total_count), .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   // ---------------- engine model ----------------
   logic [DW-1:0] score_tab [0:3];
   logic          hang_en = 1'b0;
   logic [DW-1:0] hang_m  = '0;
   int            eng_cnt = 0;
   logic          eng_fired = 1'b0;

   always @(negedge clk) begin
      if (rst || eng_rst) begin
         eng_cnt = 0; eng_fired = 1'b0; eng_score_ready = 1'b0;
      end else if (eng_score_received) begin
         eng_score_ready = 1'b0; eng_fired = 1'b1;
      end else if (!eng_fired && !eng_score_ready) begin
         eng_cnt++;
         if (eng_cnt >= ENG_LAT && !(hang_en && eng_m == hang_m)) begin
            eng_score       = score_tab[eng_m[1:0]];
            eng_score_ready = 1'b1;
         end
      end
   end

   // ---------------- monitors ----------------
   logic [MW-1:0] we_addr_q [$];
   logic [DW-1:0] we_data_q [$];
   logic [DW-1:0] run_m_q [$];
   int            done_cnt = 0;
   int            beam_bad = 0;
   logic [DW-1:0] beam_ref = '0;
   logic          prev_eng_rst = 1'b1;

   always @(negedge clk) begin
      if (res_we === 1'b1) begin
         we_addr_q.push_back(res_addr);
         we_data_q.push_back(res_data);
      end
      if (frame_done === 1'b1) done_cnt++;
      if (prev_eng_rst === 1'b1 && eng_rst === 1'b0) run_m_q.push_back(eng_m);
      if (busy === 1'b1 && eng_beam !== beam_ref) beam_bad++;
      prev_eng_rst = eng_rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_frame(input logic [MW-1:0] n, input logic [DW-1:0] b);
      @(negedge clk);
      frame_start = 1'b1; n_mgau = n; beam = b;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (frame_done === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_runs(input int target, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (run_m_q.size() >= target) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // Returns the idx-th recorded write; out-of-range reads yield an impossible pair.
   task automatic get_write(input int idx, output logic [MW-1:0] a, output logic [DW-1:0] d);
      a = 'x; d = 'x;
      if (idx < we_addr_q.size()) begin a = we_addr_q[idx]; d = we_data_q[idx]; end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      n_assert++;
      if ({eng_rst, busy, frame_done, res_we, eng_score_received, err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 100000",
                  {eng_rst, busy, frame_done, res_we, eng_score_received, err});
      end
      n_assert++;
      if ({eng_m, eng_beam, total_count, res_data, res_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: eng_m=%0h eng_beam=%0h total=%0h res_data=%0h res_addr=%0h expected all 0",
                  eng_m, eng_beam, total_count, res_data, res_addr);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      logic [MW-1:0] a; logic [DW-1:0] d;
      logic [DW-1:0] exp_d [0:2];
      int w0, r0, d0, b0; bit ok;
      exp_d[0] = 5; exp_d[1] = 3; exp_d[2] = 7;
      score_tab[0] = 5; score_tab[1] = 3; score_tab[2] = 7;
      beam_ref = BEAM_A;
      w0 = we_addr_q.size(); r0 = run_m_q.size(); d0 = done_cnt; b0 = beam_bad;
      start_frame(8'd3, BEAM_A);
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
      wait_done(1000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: frame_done not seen expected within 1000 cycles"); end
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 1", busy); end
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         get_write(w0 + i, a, d);
         n_assert++;
         if ({a, d} !== {MW'(i), exp_d[i]}) begin
            n_fail++;
            $display("FAIL basic_write%0d: got (%0d,%0d) expected (%0d,%0d)", i, a, d, i, exp_d[i]);
         end
      end
      n_assert++;
      if (we_addr_q.size() - w0 != 3) begin
         n_fail++; $display("FAIL basic_write_count: got %0d expected 3", we_addr_q.size() - w0);
      end
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (run_m_q.size() <= r0 + i || run_m_q[r0 + i] !== DW'(i)) begin
            n_fail++;
            $display("FAIL basic_eng_m%0d: got %0h expected %0d",
                     i, (run_m_q.size() > r0 + i) ? run_m_q[r0 + i] : 32'hDEAD_BEEF, i);
         end
      end
      n_assert++;
      if (total_count !== 32'd15) begin n_fail++; $display("FAIL basic_total: got %0d expected 15", total_count); end
      n_assert++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
      n_assert++;
      if (beam_bad != b0 || eng_beam !== BEAM_A) begin
         n_fail++; $display("FAIL basic_beam: eng_beam=%0h glitches=%0d expected %0h 0", eng_beam, beam_bad - b0, BEAM_A);
      end
      n_assert++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
   endtask

   task automatic test_zero_mgau();
      int w0, r0;
      w0 = we_addr_q.size(); r0 = run_m_q.size();
      @(negedge clk);
      frame_start = 1'b1; n_mgau = 8'd0; beam = BEAM_B; beam_ref = BEAM_B;
      @(negedge clk);
      frame_start = 1'b0;
      n_assert++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early: got %b expected 0", frame_done); end
      @(negedge clk);
      n_assert++;
      if (frame_done !== 1'b1) begin n_fail++; $display("FAIL zero_done_latency: got %b expected 1", frame_done); end
      repeat (3) @(negedge clk);
      n_assert++;
      if (we_addr_q.size() != w0) begin n_fail++; $display("FAIL zero_no_write: got %0d writes expected 0", we_addr_q.size() - w0); end
      n_assert++;
      if (run_m_q.size() != r0 || eng_rst !== 1'b1) begin
         n_fail++; $display("FAIL zero_eng_rst: runs=%0d eng_rst=%b expected 0 1", run_m_q.size() - r0, eng_rst);
      end
      n_assert++;
      if (total_count !== '0) begin n_fail++; $display("FAIL zero_total: got %0d expected 0", total_count); end
   endtask

   task automatic test_clamp();
      logic [MW-1:0] a; logic [DW-1:0] d;
      int w0; bit ok;
      score_tab[0] = 11; score_tab[1] = 22; score_tab[2] = 33; score_tab[3] = 44;
      beam_ref = BEAM_A;
      w0 = we_addr_q.size();
      start_frame(8'd9, BEAM_A);
      wait_done(1000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL clamp_done_timeout: frame_done not seen expected within 1000 cycles"); end
      repeat (4) @(negedge clk);
      n_assert++;
      if (we_addr_q.size() - w0 != 3) begin n_fail++; $display("FAIL clamp_runs: got %0d expected 3", we_addr_q.size() - w0); end
      for (int i = 0; i < 3; i++) begin
         get_write(w0 + i, a, d);
         n_assert++;
         if (a !== MW'(i)) begin n_fail++; $display("FAIL clamp_addr%0d: got %0d expected %0d", i, a, i); end
      end
      n_assert++;
      if (total_count !== 32'd66) begin n_fail++; $display("FAIL clamp_total: got %0d expected 66", total_count); end
   endtask

   task automatic test_repulse();
      int w0, r0, d0, b0; bit ok;
      score_tab[0] = 4; score_tab[1] = 6;
      beam_ref = BEAM_A;
      w0 = we_addr_q.size(); r0 = run_m_q.size(); d0 = done_cnt; b0 = beam_bad;
      start_frame(8'd2, BEAM_A);
      wait_runs(r0 + 2, 500, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL repulse_run1_timeout: run of m=1 not seen expected within 500 cycles"); end
      repeat (3) @(negedge clk);
      frame_start = 1'b1; n_mgau = 8'd3; beam = BEAM_B;
      @(negedge clk);
      frame_start = 1'b0;
      n_assert++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL repulse_busy: got %b expected 1", busy); end
      wait_done(1000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL repulse_done_timeout: frame_done not seen expected within 1000 cycles"); end
      repeat (6) @(negedge clk);
      n_assert++;
      if (we_addr_q.size() - w0 != 2 || run_m_q.size() - r0 != 2) begin
         n_fail++; $display("FAIL repulse_runs: writes=%0d runs=%0d expected 2 2", we_addr_q.size() - w0, run_m_q.size() - r0);
      end
      n_assert++;
      if (total_count !== 32'd10) begin n_fail++; $display("FAIL repulse_total: got %0d expected 10", total_count); end
      n_assert++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL repulse_done: dones=%0d busy=%b expected 1 0", done_cnt - d0, busy);
      end
      n_assert++;
      if (beam_bad != b0) begin n_fail++; $display("FAIL repulse_beam: got %0d glitches expected 0", beam_bad - b0); end
   endtask

   task automatic test_reset_mid_frame();
      logic [MW-1:0] a; logic [DW-1:0] d;
      int w0, r0, d0; bit ok;
      score_tab[0] = 5; score_tab[1] = 3; score_tab[2] = 7;
      beam_ref = BEAM_A;
      w0 = we_addr_q.size(); r0 = run_m_q.size(); d0 = done_cnt;
      start_frame(8'd3, BEAM_A);
      wait_runs(r0 + 2, 500, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_run1_timeout: run of m=1 not seen expected within 500 cycles"); end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_assert++;
      if ({eng_rst, busy, res_we, frame_done, eng_score_received} !== 5'b10000 || total_count !== '0 || eng_m !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async: ctrl=%b total=%0d eng_m=%0d expected 10000 0 0",
                  {eng_rst, busy, res_we, frame_done, eng_score_received}, total_count, eng_m);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_assert++;
      if (we_addr_q.size() - w0 != 1 || done_cnt != d0) begin
         n_fail++; $display("FAIL rstmid_abort: writes=%0d dones=%0d expected 1 0", we_addr_q.size() - w0, done_cnt - d0);
      end
      score_tab[0] = 9; score_tab[1] = 8; score_tab[2] = 7;
      beam_ref = BEAM_B;
      w0 = we_addr_q.size(); r0 = run_m_q.size();
      start_frame(8'd3, BEAM_B);
      wait_done(1000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout: frame_done not seen expected within 1000 cycles"); end
      repeat (4) @(negedge clk);
      n_assert++;
      if (run_m_q.size() <= r0 || run_m_q[r0] !== '0) begin
         n_fail++; $display("FAIL rstmid_restart_m: got %0h expected 0", (run_m_q.size() > r0) ? run_m_q[r0] : 32'hDEAD_BEEF);
      end
      for (int i = 0; i < 3; i++) begin
         get_write(w0 + i, a, d);
         n_assert++;
         if ({a, d} !== {MW'(i), DW'(9 - i)}) begin
            n_fail++; $display("FAIL rstmid_write%0d: got (%0d,%0d) expected (%0d,%0d)", i, a, d, i, 9 - i);
         end
      end
      n_assert++;
      if (total_count !== 32'd24) begin n_fail++; $display("FAIL rstmid_total: got %0d expected 24", total_count); end
   endtask

`ifdef SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      logic [MW-1:0] a; logic [DW-1:0] d;
      logic [DW-1:0] exp_d [0:2];
      int w0; bit ok;
      exp_d[0] = 5; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 7;
      score_tab[0] = 5; score_tab[1] = 3; score_tab[2] = 7;
      hang_en = 1'b1; hang_m = 1;
      beam_ref = BEAM_A;
      w0 = we_addr_q.size();
      start_frame(8'd3, BEAM_A);
      wait_done(2000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL wd_done_timeout: frame_done not seen expected within 2000 cycles"); end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         get_write(w0 + i, a, d);
         n_assert++;
         if ({a, d} !== {MW'(i), exp_d[i]}) begin
            n_fail++; $display("FAIL wd_write%0d: got (%0d,%0h) expected (%0d,%0h)", i, a, d, i, exp_d[i]);
         end
      end
      n_assert++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL wd_err: got %b expected 1", err); end
      n_assert++;
      if (total_count !== 32'd12) begin n_fail++; $display("FAIL wd_total: got %0d expected 12", total_count); end
      hang_en = 1'b0;
   endtask
`endif

   initial begin
      score_tab[0] = '0; score_tab[1] = '0; score_tab[2] = '0; score_tab[3] = '0;
      test_reset();
      test_basic_frame();
      test_zero_mgau();
      test_clamp();
      test_repulse();
      test_reset_mid_frame();
`ifdef SCHED_WATCHDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at 2000000 expected finish earlier");
      $fatal(1, "global timeout");
   end

endmodule
